stack_mem_controller: RTL and testbench

//  Memory-side responder for CPU stack traffic: executes push/pull requests from the

---
 rtl/stack_mem_controller.sv | 147 ++++++++++++++
 tb/tb_stack_mem_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_controller.sv
// Stack-page memory responder: executes 8/16-bit push/pull requests byte by byte
// against the shared memory bus and owns the 8-bit stack pointer.
module stack_mem_controller #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] SP_RESET   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_pull,
  input  logic        req_wide,
  input  logic [15:0] req_data,
  output logic        done,
  output logic [15:0] resp_data,
  input  logic        sp_load,
  input  logic [7:0]  sp_load_val,
  output logic [7:0]  sp_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        err_ovf,
  output logic        err_unf
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_HI = 3'd1,
    PUSH_LO = 3'd2,
    PULL_LO = 3'd3,
    PULL_HI = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [7:0]  sp, sp_next, sp_inc;
  logic [15:0] data_q;
  logic        wide_q;
  logic [7:0]  pull_lo_q;
  logic        accept;

  assign sp_out = sp;
  assign sp_inc = sp + 8'd1;

  // NOTE: every output and next-state value gets a default first so no path
  // through the case statement leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    sp_next    = sp;
    accept     = 1'b0;
    req_ready  = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 8'h00;
    err_ovf    = 1'b0;
    err_unf    = 1'b0;

    case (state)
      IDLE: begin
        // A stack-pointer load wins over a request and stalls it for one cycle.
        req_ready = ~sp_load;
        if (sp_load) begin
          sp_next = sp_load_val;
        end else if (req_valid) begin
          accept = 1'b1;
          if (req_pull)      state_next = PULL_LO;
          else if (req_wide) state_next = PUSH_HI;
          else               state_next = PUSH_LO;
        end
      end

      PUSH_HI, PUSH_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = (state == PUSH_HI) ? data_q[15:8] : data_q[7:0];
        if (mem_ack) begin
          sp_next    = sp - 8'd1;
          err_ovf    = (sp == 8'h00);
          state_next = (state == PUSH_HI) ? PUSH_LO : DONE;
        end
      end

      PULL_LO, PULL_HI: begin
        mem_req  = 1'b1;
        mem_addr = {STACK_PAGE, sp_inc};
        if (mem_ack) begin
          sp_next    = sp_inc;
          err_unf    = (sp == 8'hFF);
          state_next = (state == PULL_LO && wide_q) ? PULL_HI : DONE;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sp    <= SP_RESET;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
      sp    <= sp_next;
    end
  end

  // Request latch and response assembly; resp_data changes only when a pull
  // completes or is cleared by a completing push.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= 16'h0000;
      wide_q    <= 1'b0;
      pull_lo_q <= 8'h00;
      resp_data <= 16'h0000;
    end else begin
      if (accept) begin
        data_q <= req_data;
        wide_q <= req_wide;
      end
      if (mem_ack) begin
        case (state)
          PUSH_LO: resp_data <= 16'h0000;
          PULL_LO: begin
            pull_lo_q <= mem_rdata;
            if (!wide_q) resp_data <= {8'h00, mem_rdata};
          end
          PULL_HI: resp_data <= {mem_rdata, pull_lo_q};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_mem_controller.sv
// Bench for stack_mem_controller: directed vector table, hand-written corner
// sequences and a randomized run against a stack/memory reference model.
module tb_stack_mem_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_pull = 1'b0, req_wide = 1'b0;
  logic [15:0] req_data = 16'h0000;
  logic        done;
  logic [15:0] resp_data;
  logic        sp_load = 1'b0;
  logic [7:0]  sp_load_val = 8'h00;
  logic [7:0]  sp_out;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        err_ovf, err_unf;

  always #5 clk = ~clk;

  stack_mem_controller dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_pull(req_pull),
    .req_wide(req_wide), .req_data(req_data),
    .done(done), .resp_data(resp_data),
    .sp_load(sp_load), .sp_load_val(sp_load_val), .sp_out(sp_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  bus_mem [256];
  logic [7:0]  mdl_mem [256];
  int          ack_wait = 0;
  int          wait_cnt = 0;
  int          cyc = 0;
  int          done_cnt = 0, ovf_cnt = 0, unf_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] resp_at_done = 16'h0000;
  logic [15:0] acc_q [$];
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [63:0] prev_bus = 64'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder and bus monitor: drives ack/rdata at the falling edge,
  // then observes the settled outputs 1 time unit later.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && mem_req && wait_cnt >= ack_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = bus_mem[mem_addr[7:0]];
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        wait_cnt  = (!reset && mem_req) ? wait_cnt + 1 : 0;
      end
      #1;
      if (!reset) begin
        if (done) begin
          done_cnt++;
          resp_at_done = resp_data;
          done_cyc = cyc;
        end
        if (err_ovf) ovf_cnt++;
        if (err_unf) unf_cnt++;
        if (mem_req && prev_req && !prev_ack)
          check("bus_stable_while_waiting", {31'h0, mem_we, mem_addr, mem_wdata, sp_out}, prev_bus);
        if (mem_req && mem_ack) begin
          check("addr_page", mem_addr[15:8], 8'h01);
          acc_q.push_back(mem_addr);
          if (mem_we) bus_mem[mem_addr[7:0]] = mem_wdata;
        end
      end
      prev_req = mem_req && !reset;
      prev_ack = mem_ack;
      prev_bus = {31'h0, mem_we, mem_addr, mem_wdata, sp_out};
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request and waits (bounded) for its done pulse; lat is the
  // accept-cycle to done-cycle distance.
  task automatic do_op(input logic pull, input logic wide, input logic [15:0] data,
                       input int wn, output int lat);
    int acc_cyc;
    int d0;
    ack_wait = wn;
    d0 = done_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_pull = pull; req_wide = wide; req_data = data;
    #1;
    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(posedge clk); #2;
    end
    check("req_ready_for_accept", req_ready, 1'b1);
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(posedge clk);
    check("done_seen", done_cnt != d0, 1'b1);
    lat = done_cyc - acc_cyc;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        pull;
    logic        wide;
    logic [15:0] data;
    int          wn;
    logic [15:0] addr0;
    logic [7:0]  sp;
    logic [15:0] resp;
    int          ovf;
    int          unf;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat, d_ovf, d_unf, d_done, qs, mism;
    logic [7:0]  msp;
    logic [15:0] mresp;
    logic [7:0]  lo, hi;
    logic        pull, wide;
    logic [15:0] data;
    int          wn, exp_ovf, exp_unf;

    for (int i = 0; i < 256; i++) bus_mem[i] = ~8'(i);

    //          pull  wide  data     wn addr0    sp     resp     ovf unf
    vecs[0] = '{1'b0, 1'b0, 16'h00A5, 0, 16'h01FF, 8'hFE, 16'h0000, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 0, 16'h01FF, 8'hFF, 16'h00A5, 0, 0};
    vecs[2] = '{1'b0, 1'b1, 16'h1234, 0, 16'h01FF, 8'hFD, 16'h0000, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 16'h0000, 0, 16'h01FE, 8'hFF, 16'h1234, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 0, 16'h0100, 8'h00, 16'h00FF, 0, 1};
    vecs[5] = '{1'b0, 1'b0, 16'h003C, 0, 16'h0100, 8'hFF, 16'h0000, 1, 0};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 1, 16'h0100, 8'h00, 16'h003C, 0, 1};
    vecs[7] = '{1'b0, 1'b1, 16'hBEEF, 3, 16'h0100, 8'hFE, 16'h0000, 1, 0};
    vecs[8] = '{1'b1, 1'b1, 16'h0000, 2, 16'h01FF, 8'h00, 16'hBEEF, 0, 1};
    vecs[9] = '{1'b0, 1'b0, 16'h0077, 1, 16'h0100, 8'hFF, 16'h0000, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_sp", sp_out, 8'hFF);
    check("rst_ready", req_ready, 1'b1);
    check("rst_outputs", {done, mem_req, mem_we, err_ovf, err_unf, mem_addr, mem_wdata, resp_data},
          '0);

    // Directed vector table
    foreach (vecs[i]) begin
      d_ovf = ovf_cnt; d_unf = unf_cnt; d_done = done_cnt; qs = acc_q.size();
      do_op(vecs[i].pull, vecs[i].wide, vecs[i].data, vecs[i].wn, lat);
      check($sformatf("v%0d_sp", i), sp_out, vecs[i].sp);
      check($sformatf("v%0d_resp_at_done", i), resp_at_done, vecs[i].resp);
      check($sformatf("v%0d_resp_held", i), resp_data, vecs[i].resp);
      check($sformatf("v%0d_ovf", i), ovf_cnt - d_ovf, vecs[i].ovf);
      check($sformatf("v%0d_unf", i), unf_cnt - d_unf, vecs[i].unf);
      check($sformatf("v%0d_done_once", i), done_cnt - d_done, 1);
      check($sformatf("v%0d_addr0", i), (acc_q.size() > qs) ? acc_q[qs] : 16'hxxxx, vecs[i].addr0);
      check($sformatf("v%0d_latency", i), lat, (vecs[i].wide ? 2 : 1) * (vecs[i].wn + 1) + 1);
    end

    // sp_load holds off a pending request for one cycle, then it is accepted
    d_done = done_cnt;
    ack_wait = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_pull = 1'b0; req_wide = 1'b0; req_data = 16'h0011;
    sp_load = 1'b1; sp_load_val = 8'h80;
    #1;
    check("load_blocks_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    sp_load = 1'b0;
    #1;
    check("sp_loaded", sp_out, 8'h80);
    check("held_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20 && done_cnt == d_done; i++) @(posedge clk);
    @(posedge clk); #1;
    check("held_push_done", done_cnt - d_done, 1);
    check("held_push_sp", sp_out, 8'h7F);
    check("held_push_mem", bus_mem[8'h80], 8'h11);

    // Reset in PUSH_LO of a wide push aborts it; sp_load there is ignored
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    d_done = done_cnt; qs = acc_q.size();
    ack_wait = 3;
    req_valid = 1'b1; req_pull = 1'b0; req_wide = 1'b1; req_data = 16'h5566;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20 && acc_q.size() == qs; i++) @(posedge clk);
    #1;
    check("abort_lo_wdata", {mem_req, mem_we, mem_wdata}, {1'b1, 1'b1, 8'h66});
    check("abort_sp_mid", sp_out, 8'hFE);
    sp_load = 1'b1; sp_load_val = 8'h33;
    @(posedge clk); #1;
    sp_load = 1'b0;
    check("sp_load_ignored_busy", sp_out, 8'hFE);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_mem_req_low", mem_req, 1'b0);
    check("abort_sp_restored", sp_out, 8'hFF);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d_done, 0);
    check("abort_resp_zero", resp_data, 16'h0000);

    // Randomized run against the reference model
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      mdl_mem[i] = bus_mem[i];
    end
    msp = 8'hFF;
    mresp = 16'h0000;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
        sp_load = 1'b1; sp_load_val = 8'($urandom);
        msp = sp_load_val;
        @(posedge clk); #1;
        sp_load = 1'b0;
        check("rnd_sp_load", sp_out, msp);
      end else begin
        pull = 1'($urandom); wide = 1'($urandom);
        data = 16'($urandom); wn = $urandom_range(0, 2);
        exp_ovf = 0; exp_unf = 0;
        if (!pull) begin
          if (wide) begin
            mdl_mem[msp] = data[15:8];
            if (msp == 8'h00) exp_ovf++;
            msp = msp - 8'd1;
          end
          mdl_mem[msp] = data[7:0];
          if (msp == 8'h00) exp_ovf++;
          msp = msp - 8'd1;
          mresp = 16'h0000;
        end else begin
          if (msp == 8'hFF) exp_unf++;
          msp = msp + 8'd1;
          lo = mdl_mem[msp];
          hi = 8'h00;
          if (wide) begin
            if (msp == 8'hFF) exp_unf++;
            msp = msp + 8'd1;
            hi = mdl_mem[msp];
          end
          mresp = {hi, lo};
        end
        d_ovf = ovf_cnt; d_unf = unf_cnt; d_done = done_cnt;
        do_op(pull, wide, data, wn, lat);
        check("rnd_sp", sp_out, msp);
        check("rnd_resp", resp_data, mresp);
        check("rnd_ovf", ovf_cnt - d_ovf, exp_ovf);
        check("rnd_unf", unf_cnt - d_unf, exp_unf);
        check("rnd_done_once", done_cnt - d_done, 1);
        check("rnd_latency", lat, (wide ? 2 : 1) * (wn + 1) + 1);
      end
    end
    mism = 0;
    for (int i = 0; i < 256; i++) if (bus_mem[i] !== mdl_mem[i]) mism++;
    check("rnd_mem_image_mismatches", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
